move_sequencer: RTL and testbench
=================================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 50000; the number of clock cycles each servo step is held (legal range 2..2^24).
REQ-002 SHALL have port I_sys_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port I_sys_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port I_enable  input  1  move acceptance enable (driven by scanner-done); level.
REQ-005 SHALL have port I_move_leftRow  input  1  left-row move request; debounced, synchronous level.
REQ-006 SHALL have port I_move_rightRow  input  1  right-row move request; debounced, synchronous level.
REQ-007 SHALL have port I_move_topRow  input  1  top-row move request; debounced, synchronous level.
REQ-008 SHALL have port I_move_bottomRow  input  1  bottom-row move request; debounced, synchronous level.
REQ-009 SHALL have port o_dir  output  4  directional servo command per servo [0..3]; 1 = rotated 90 deg, 0 = home.
REQ-010 SHALL have port o_grip  output  4  gripping servo command per servo [0..3]; 1 = closed, 0 = open.
REQ-011 SHALL have port o_busy  output  1  high while a move is in progress (any state other than IDLE).
REQ-012 SHALL have port o_done  output  1  one-cycle pulse at the end of each move.

Function
REQ-013 SHALL map requests to servo index: leftRow->0, rightRow->1, topRow->2, bottomRow->3.
REQ-014 SHALL register each request input every cycle and detect a rising edge (current 1, previous 0).
REQ-015 SHALL accept a move only when state = IDLE, I_enable = 1, and at least one rising edge is detected in that cycle.
REQ-016 SHALL resolve simultaneous edges by fixed priority left > right > top > bottom; lower-priority edges in the same cycle are discarded.
REQ-017 SHALL discard all edges arriving while not IDLE; there is no queuing.
REQ-018 SHALL implement states IDLE, ROTATE, RELEASE, RETURN, REGRIP, DONE, with transitions IDLE->ROTATE (on accept), ROTATE->RELEASE->RETURN->REGRIP (each after STEP_CYCLES cycles), REGRIP->DONE (after STEP_CYCLES cycles), DONE->IDLE (unconditionally after 1 cycle).
REQ-019 SHALL, for selected servo n, drive o_dir[n]=1 in ROTATE, o_grip[n]=0 in RELEASE, o_dir[n]=0 in RETURN, and o_grip[n]=1 in REGRIP; each output is registered and holds its value until changed by a later step.
REQ-020 SHALL leave all non-selected servo bits unchanged throughout a move.
REQ-021 SHALL make the o_dir[n] rise visible in the cycle following the accepting edge, and keep each of the four steps exactly STEP_CYCLES cycles long; o_busy is high for 4*STEP_CYCLES+1 cycles per move.
REQ-022 SHALL reset the step counter to 0 on each state entry, size it with $clog2(STEP_CYCLES), and advance state when the count = STEP_CYCLES-1; the counter never wraps.
REQ-023 SHALL assert o_done only in DONE; o_busy is low in IDLE only.
REQ-024 SHALL ignore a deassertion of I_enable during a move; the move completes normally.

Reset
REQ-025 SHALL, while I_sys_rst_n = 0, asynchronously force state = IDLE, counter = 0, o_dir = 4'b0000, o_grip = 4'b1111, o_busy = 0, o_done = 0.
REQ-026 SHALL reset the request-history registers to 1, so a request held high through reset release does not trigger a move until it is released and re-pressed.
REQ-027 SHALL abort any move in progress when reset is asserted; no o_done is produced for the aborted move.

Verification (STEP_CYCLES=4)
REQ-028 SHALL verify single left move: I_enable=1, leftRow 0->1 -> o_dir=0001 for 4 cycles, o_grip=1110 for 4, o_dir=0000 for 4, o_grip=1111 for 4, then o_done pulse; o_busy high for 17 cycles.
REQ-029 SHALL verify priority: rightRow and bottomRow rise in the same cycle -> only servo 1 sequences, and bits 3 of o_dir/o_grip stay 0/1.
REQ-030 SHALL verify gating: a topRow edge with I_enable=0, and a leftRow edge during a busy move -> neither starts a move, and o_done pulses once total.
REQ-031 SHALL verify reset mid-move: I_sys_rst_n low during RELEASE -> outputs immediately become o_dir=0000, o_grip=1111, o_busy=0, with no o_done.
REQ-032 SHALL verify held-through-reset: bottomRow held high across reset release -> no move; after release and re-press -> servo 3 move.
REQ-033 SHALL verify enable drop: I_enable cleared during ROTATE -> the move completes and o_done pulses.

Source files
------------

// File: rtl/move_sequencer.sv
// move_sequencer: runs one four-step servo move (rotate, release, return,
// regrip) for a single selected servo, triggered by a rising edge on one of
// the four row-move requests while the sequencer is idle and enabled.
//
// Handshake: a move request is a rising edge (level now 1, last cycle 0)
// on I_move_*. It is taken only in IDLE with I_enable high. Edges seen at
// any other time are dropped and never queued. o_busy stays high from the
// cycle after acceptance until the DONE cycle, inclusive. o_done is a
// single-cycle pulse in DONE.
module move_sequencer #(
    parameter int unsigned STEP_CYCLES = 50000
) (
    input  logic       I_sys_clk,
    input  logic       I_sys_rst_n,
    input  logic       I_enable,
    input  logic       I_move_leftRow,
    input  logic       I_move_rightRow,
    input  logic       I_move_topRow,
    input  logic       I_move_bottomRow,
    output logic [3:0] o_dir,
    output logic [3:0] o_grip,
    output logic       o_busy,
    output logic       o_done,
    output logic [2:0] o_state_dbg
);

    localparam int unsigned CNT_W = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ROTATE  = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RETURN  = 3'd3,
        ST_REGRIP  = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       dir_q, dir_d;
    logic [3:0]       grip_q, grip_d;
    logic [3:0]       req_q;

    logic [3:0] req;
    logic [3:0] edge_det;
    logic [1:0] pick;
    logic       step_done;

    // Servo index order: left=0, right=1, top=2, bottom=3.
    assign req      = {I_move_bottomRow, I_move_topRow, I_move_rightRow, I_move_leftRow};
    assign edge_det = req & ~req_q;
    assign step_done = (cnt_q == CNT_LAST);

    // Fixed-priority pick among simultaneous edges: lowest index wins.
    always_comb begin
        pick = 2'd3;
        if (edge_det[0]) begin
            pick = 2'd0;
        end else if (edge_det[1]) begin
            pick = 2'd1;
        end else if (edge_det[2]) begin
            pick = 2'd2;
        end
    end

    // Request history; resets high so a request held through reset needs a re-press.
    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
        if (!I_sys_rst_n) begin
            req_q <= 4'b1111;
        end else begin
            req_q <= req;
        end
    end

    // Sequencer state, step counter, selected servo and servo command registers.
    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
        if (!I_sys_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            dir_q   <= 4'b0000;
            grip_q  <= 4'b1111;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            grip_q  <= grip_d;
        end
    end

    // Next-state logic; servo bits change on the edge that enters each step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        grip_d  = grip_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (I_enable && (|edge_det)) begin
                    state_d     = ST_ROTATE;
                    sel_d       = pick;
                    dir_d[pick] = 1'b1;
                end
            end
            ST_ROTATE: begin
                if (step_done) begin
                    state_d       = ST_RELEASE;
                    cnt_d         = '0;
                    grip_d[sel_q] = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (step_done) begin
                    state_d      = ST_RETURN;
                    cnt_d        = '0;
                    dir_d[sel_q] = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RETURN: begin
                if (step_done) begin
                    state_d       = ST_REGRIP;
                    cnt_d         = '0;
                    grip_d[sel_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REGRIP: begin
                if (step_done) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_dir       = dir_q;
    assign o_grip      = grip_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign o_state_dbg = state_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with STEP_CYCLES=4. Stimulus pushes the
// expected servo mask of each move; a monitor classifies every busy cycle and
// checks step lengths when o_done appears.
module tb_move_sequencer;

    localparam int unsigned STEP = 4;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       left, right, top, bottom;
    logic [3:0] dir, grip;
    logic       busy, done;
    logic [2:0] state_dbg;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    logic [3:0] exp_q[$];

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    move_sequencer #(.STEP_CYCLES(STEP)) dut (
        .I_sys_clk        (clk),
        .I_sys_rst_n      (rst_n),
        .I_enable         (enable),
        .I_move_leftRow   (left),
        .I_move_rightRow  (right),
        .I_move_topRow    (top),
        .I_move_bottomRow (bottom),
        .o_dir            (dir),
        .o_grip           (grip),
        .o_busy           (busy),
        .o_done           (done),
        .o_state_dbg      (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int seen_idle;
        seen_idle = 0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) begin
                seen_idle = 1;
                break;
            end
            tick(1);
        end
        check({name, "_idle_timeout"}, 32'(seen_idle), 32'd1);
    endtask

    task automatic check_home(input string name);
        check({name, "_dir"},  32'(dir),  32'h0);
        check({name, "_grip"}, 32'(grip), 32'hF);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
    endtask

    // scoreboard monitor
    int busy_len, c_rot, c_rel, c_ret, c_reg, c_oth;
    logic [3:0] m;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_len = 0; c_rot = 0; c_rel = 0; c_ret = 0; c_reg = 0; c_oth = 0;
        end else begin
            if (busy) busy_len++;
            if (busy && !done && exp_q.size() != 0) begin
                m = exp_q[0];
                if (dir == m && grip == 4'hF)          c_rot++;
                else if (dir == m && grip == ~m)       c_rel++;
                else if (dir == 4'h0 && grip == ~m)    c_ret++;
                else if (dir == 4'h0 && grip == 4'hF)  c_reg++;
                else                                   c_oth++;
            end
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    m = exp_q.pop_front();
                    check("busy_len",     32'(busy_len), 32'(4 * STEP + 1));
                    check("rotate_len",   32'(c_rot),    32'(STEP));
                    check("release_len",  32'(c_rel),    32'(STEP));
                    check("return_len",   32'(c_ret),    32'(STEP));
                    check("regrip_len",   32'(c_reg),    32'(STEP));
                    check("other_cycles", 32'(c_oth),    32'd0);
                end
                busy_len = 0; c_rot = 0; c_rel = 0; c_ret = 0; c_reg = 0; c_oth = 0;
            end
        end
    end

    int snap;

    initial begin
        rst_n = 1'b0; enable = 1'b0;
        left = 1'b0; right = 1'b0; top = 1'b0; bottom = 1'b0;
        tick(3);
        check_home("reset");
        rst_n = 1'b1;
        tick(2);
        check_home("post_reset");

        // single left move
        enable = 1'b1;
        exp_q.push_back(4'b0001);
        left = 1'b1;
        tick(1);
        check("left_first_dir", 32'(dir), 32'h1);
        check("left_first_busy", 32'(busy), 32'd1);
        left = 1'b0;
        wait_idle("left");
        check_home("left_end");

        // priority: right and bottom together
        exp_q.push_back(4'b0010);
        right = 1'b1; bottom = 1'b1;
        tick(1);
        right = 1'b0; bottom = 1'b0;
        wait_idle("prio");

        // gating: edge with enable low, then edge during a busy move
        snap = done_cnt;
        enable = 1'b0;
        top = 1'b1;
        tick(3);
        check("gated_top_busy", 32'(busy), 32'd0);
        top = 1'b0;
        tick(1);
        enable = 1'b1;
        exp_q.push_back(4'b0010);
        right = 1'b1;
        tick(2);
        left = 1'b1;
        tick(2);
        left = 1'b0; right = 1'b0;
        wait_idle("gate");
        tick(4);
        check("gate_done_count", 32'(done_cnt - snap), 32'd1);
        check("gate_busy_after", 32'(busy), 32'd0);

        // reset during RELEASE
        exp_q.push_back(4'b0100);
        top = 1'b1;
        tick(1);
        top = 1'b0;
        tick(STEP + 1);
        check("midmove_grip", 32'(grip), 32'hB);
        snap = done_cnt;
        rst_n = 1'b0;
        #1;
        check_home("abort");
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("abort_no_done", 32'(done_cnt - snap), 32'd0);

        // bottom held through reset release
        rst_n = 1'b0;
        bottom = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check("held_no_move", 32'(busy), 32'd0);
        bottom = 1'b0;
        tick(1);
        exp_q.push_back(4'b1000);
        bottom = 1'b1;
        tick(1);
        bottom = 1'b0;
        check("bottom_first_dir", 32'(dir), 32'h8);
        wait_idle("bottom");

        // enable dropped during ROTATE
        snap = done_cnt;
        exp_q.push_back(4'b0001);
        left = 1'b1;
        tick(1);
        enable = 1'b0;
        left = 1'b0;
        wait_idle("endrop");
        check("endrop_done", 32'(done_cnt - snap), 32'd1);
        enable = 1'b1;

        tick(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("total_moves", 32'(done_cnt), 32'd5);
        check_home("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
